// File: rtl/gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gate_seq_ctrl
// Description : Exhaustive two-input gate tester. On start, drives the four
//               input vectors (a,b) = 00, 10, 01, 11 onto the gate under
//               test, holding each for HOLD_CYCLES clocks. On the last clock
//               of each hold it samples the gate output c, compares it with
//               the expected truth table TT_EXP and accumulates results.
//               A one-cycle done pulse marks the end of a run.
// Ports       : clk       - clock, rising edge active
//               rst_n     - asynchronous active-low reset
//               start     - run request, honoured only while idle
//               abort     - cancels a run in progress, discards results
//               c         - output of the gate under test
//               a, b      - registered drives to the gate under test
//               busy      - high while vectors are being applied
//               done      - one-cycle pulse at run completion
//               pass      - last completed run had no mismatches
//               fail_mask - bit i set when vector i mismatched
//               err_cnt   - number of mismatching vectors (0..4)
//               c_cap     - sampled c for each vector i
// Revision    : 1.0 - initial release
// ============================================================================
module gate_seq_ctrl #(
    parameter int         HOLD_CYCLES = 10,
    parameter logic [3:0] TT_EXP      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] err_cnt,
    output logic [3:0] c_cap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_hcnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_fail_mask;
    logic [2:0] r_err_cnt;
    logic [3:0] r_c_cap;

    state_t     w_state_nxt;
    logic [1:0] w_idx_nxt;
    logic [7:0] w_hcnt_nxt;
    logic       w_pass_nxt;
    logic [3:0] w_fail_mask_nxt;
    logic [2:0] w_err_cnt_nxt;
    logic [3:0] w_c_cap_nxt;
    logic       w_a_nxt;
    logic       w_b_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_sample;

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= 2'd0;
            r_hcnt      <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 4'd0;
            r_err_cnt   <= 3'd0;
            r_c_cap     <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_c_cap     <= w_c_cap_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_hcnt_nxt      = r_hcnt;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_err_cnt_nxt   = r_err_cnt;
        w_c_cap_nxt     = r_c_cap;
        w_sample        = (r_hcnt == c_HOLD_LAST);

        unique case (r_state)
            IDLE: begin
                // start has priority over abort here; abort has no effect
                if (start) begin
                    w_state_nxt     = APPLY;
                    w_idx_nxt       = 2'd0;
                    w_hcnt_nxt      = 8'd0;
                    w_pass_nxt      = 1'b0;
                    w_fail_mask_nxt = 4'd0;
                    w_err_cnt_nxt   = 3'd0;
                    w_c_cap_nxt     = 4'd0;
                end
            end

            APPLY: begin
                if (abort) begin
                    w_state_nxt     = IDLE;
                    w_idx_nxt       = 2'd0;
                    w_hcnt_nxt      = 8'd0;
                    w_pass_nxt      = 1'b0;
                    w_fail_mask_nxt = 4'd0;
                    w_err_cnt_nxt   = 3'd0;
                    w_c_cap_nxt     = 4'd0;
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                    if (w_sample) begin
                        w_c_cap_nxt[r_idx] = c;
                        // At most four mismatches per run, so the 3-bit
                        // count cannot wrap.
                        if (c != TT_EXP[r_idx]) begin
                            w_fail_mask_nxt[r_idx] = 1'b1;
                            w_err_cnt_nxt          = r_err_cnt + 3'd1;
                        end
                        w_hcnt_nxt = 8'd0;
                        if (r_idx != 2'd3) begin
                            w_idx_nxt = r_idx + 2'd1;
                        end else begin
                            // pass is valid alongside done and already
                            // reflects the final vector's compare.
                            w_state_nxt = DONE;
                            w_idx_nxt   = 2'd0;
                            w_pass_nxt  = (w_fail_mask_nxt == 4'd0);
                        end
                    end
                end
            end

            DONE: begin
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 2'd0;
                w_hcnt_nxt  = 8'd0;
            end
        endcase

        // Output flops are loaded from the next state so they line up
        // exactly with the state they describe.
        w_busy_nxt = (w_state_nxt == APPLY);
        w_done_nxt = (w_state_nxt == DONE);
        w_a_nxt    = w_busy_nxt & w_idx_nxt[0];
        w_b_nxt    = w_busy_nxt & w_idx_nxt[1];
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_mask = r_fail_mask;
    assign err_cnt   = r_err_cnt;
    assign c_cap     = r_c_cap;

endmodule
`default_nettype wire

// File: tb/tb_gate_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_seq_ctrl
// Description : Self-checking bench for gate_seq_ctrl. Two instances are
//               used (HOLD_CYCLES=10 and HOLD_CYCLES=1); sel chooses which
//               one receives start/abort and is observed. The gate under
//               test is modelled by a 4-entry truth table tt indexed by
//               vector index {b,a}. Expected results are computed from the
//               truth table directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_seq_ctrl;

    localparam int         c_H0 = 10;
    localparam int         c_H1 = 1;
    localparam logic [3:0] c_TT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       sel;
    logic [3:0] tt;

    logic       a0, b0, busy0, done0, pass0, c0;
    logic [3:0] fm0, cc0;
    logic [2:0] ec0;
    logic       a1, b1, busy1, done1, pass1, c1;
    logic [3:0] fm1, cc1;
    logic [2:0] ec1;

    logic       w_start0, w_start1, w_abort0, w_abort1;
    logic       a_s, b_s, busy_s, done_s, pass_s;
    logic [3:0] fm_s, cc_s;
    logic [2:0] ec_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign c0 = tt[{b0, a0}];
    assign c1 = tt[{b1, a1}];
    assign w_start0 = start & ~sel;
    assign w_start1 = start & sel;
    assign w_abort0 = abort & ~sel;
    assign w_abort1 = abort & sel;

    assign a_s    = sel ? a1 : a0;
    assign b_s    = sel ? b1 : b0;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign pass_s = sel ? pass1 : pass0;
    assign fm_s   = sel ? fm1 : fm0;
    assign cc_s   = sel ? cc1 : cc0;
    assign ec_s   = sel ? ec1 : ec0;

    gate_seq_ctrl #(.HOLD_CYCLES(c_H0), .TT_EXP(c_TT)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(w_start0), .abort(w_abort0), .c(c0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_mask(fm0), .err_cnt(ec0), .c_cap(cc0)
    );

    gate_seq_ctrl #(.HOLD_CYCLES(c_H1), .TT_EXP(c_TT)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(w_start1), .abort(w_abort1), .c(c1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fm1), .err_cnt(ec1), .c_cap(cc1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One run on the selected instance. restart_at / abort_at give the
    // cycle (1 = first cycle after the accepting edge) in which start /
    // abort is raised for one cycle; 0 disables. with_abort raises abort
    // together with the initial start.
    task automatic run_check(input logic [3:0] t, input int restart_at,
                             input int abort_at, input bit with_abort,
                             input string nm);
        int         h;
        int         last;
        bit         aborted;
        logic [3:0] e_cap, e_fm;
        logic [2:0] e_ec;
        logic       e_pass;
        h       = sel ? c_H1 : c_H0;
        last    = 4 * h;
        aborted = (abort_at > 0) && (abort_at <= last);
        e_cap   = t;
        e_fm    = t ^ c_TT;
        e_ec    = 3'd0;
        for (int i = 0; i < 4; i++) e_ec = e_ec + 3'(e_fm[i]);
        e_pass  = (e_fm == 4'd0);
        if (aborted) begin
            e_cap = 4'd0; e_fm = 4'd0; e_ec = 3'd0; e_pass = 1'b0;
        end
        tt    = t;
        start = 1'b1;
        abort = with_abort;
        step();
        start = 1'b0;
        abort = 1'b0;
        for (int j = 1; j <= last + 1; j++) begin
            logic busy_e, done_e, a_e, b_e;
            int   v;
            v      = (j - 1) / h;
            busy_e = (j <= last);
            done_e = (j == last + 1);
            a_e    = busy_e ? v[0] : 1'b0;
            b_e    = busy_e ? v[1] : 1'b0;
            if (aborted && j > abort_at) begin
                busy_e = 1'b0; done_e = 1'b0; a_e = 1'b0; b_e = 1'b0;
            end
            checks++;
            if ({busy_s, done_s, a_s, b_s} !== {busy_e, done_e, a_e, b_e}) begin
                errors++;
                $display("FAIL %s seq cyc %0d: busy/done/a/b got %b%b%b%b exp %b%b%b%b",
                         nm, j, busy_s, done_s, a_s, b_s, busy_e, done_e, a_e, b_e);
            end
            if (j == 1) begin
                checks++;
                if ({pass_s, fm_s, ec_s, cc_s} !== 12'd0) begin
                    errors++;
                    $display("FAIL %s clear-on-start: pass/fm/ec/cap got %b/%b/%0d/%b exp 0",
                             nm, pass_s, fm_s, ec_s, cc_s);
                end
            end
            start = (j == restart_at);
            abort = (j == abort_at);
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        // Now idle: results must hold and no further done pulse.
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({busy_s, done_s, a_s, b_s, pass_s, fm_s, ec_s, cc_s} !==
                {4'b0000, e_pass, e_fm, e_ec, e_cap}) begin
                errors++;
                $display("FAIL %s result: busy/done/a/b=%b%b%b%b pass=%b fm=%b ec=%0d cap=%b exp pass=%b fm=%b ec=%0d cap=%b",
                         nm, busy_s, done_s, a_s, b_s, pass_s, fm_s, ec_s, cc_s,
                         e_pass, e_fm, e_ec, e_cap);
            end
            step();
        end
    endtask

    task automatic check_all_zero(input string nm);
        checks++;
        if ({a0, b0, busy0, done0, pass0, fm0, ec0, cc0,
             a1, b1, busy1, done1, pass1, fm1, ec1, cc1} !== 32'd0) begin
            errors++;
            $display("FAIL %s: outputs got fm=%b ec=%0d cap=%b pass=%b busy=%b a=%b b=%b (inst1 fm=%b cap=%b) exp all 0",
                     nm, fm0, ec0, cc0, pass0, busy0, a0, b0, fm1, cc1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 1'b0; tt = c_TT;
        repeat (3) step();
        check_all_zero("reset_state");
        rst_n = 1'b1;
        start = 1'b0;
        repeat (5) step();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_vectors();
        sel = 1'b0;
        run_check(4'b1000, 0, 0, 1'b0, "and_gate");
        run_check(4'b0000, 0, 0, 1'b0, "stuck0");
        run_check(4'b1110, 0, 0, 1'b0, "or_gate");
    endtask

    task automatic test_restart_abort();
        sel = 1'b0;
        run_check(4'b1110, 0, 0, 1'b0, "pre_abort");
        run_check(4'b1000, 5, 15, 1'b0, "restart5_abort15");
        run_check(4'b0111, 0, 41, 1'b0, "abort_in_done");
        run_check(4'b0101, 0, 40, 1'b0, "abort_last_cycle");
    endtask

    task automatic test_start_abort_idle();
        sel = 1'b0;
        run_check(4'b1001, 0, 0, 1'b1, "start_with_abort");
        tt    = 4'b0000;
        abort = 1'b1;
        repeat (3) step();
        abort = 1'b0;
        checks++;
        if ({busy_s, pass_s, fm_s, ec_s, cc_s} !== {1'b0, 1'b0, 4'b0001, 3'd1, 4'b1001}) begin
            errors++;
            $display("FAIL abort_idle: busy=%b pass=%b fm=%b ec=%0d cap=%b exp 0/0/0001/1/1001",
                     busy_s, pass_s, fm_s, ec_s, cc_s);
        end
    endtask

    task automatic test_hold1();
        sel = 1'b1;
        run_check(4'b1000, 0, 0, 1'b0, "hold1_and");
        run_check(4'b0011, 0, 0, 1'b0, "hold1_bad");
        run_check(4'b1000, 2, 3, 1'b0, "hold1_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int h, rs, ab;
            sel = 1'($urandom_range(0, 1));
            h   = sel ? c_H1 : c_H0;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * h + 1)) : 0;
            rs  = int'($urandom_range(0, 4 * h));
            if (ab != 0 && rs > ab) rs = ab;
            run_check(4'($urandom), rs, ab, 1'($urandom_range(0, 1)), "random");
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_reset_midrun();
        sel   = 1'b0;
        tt    = 4'b0110;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (25) step();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_midrun");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check_all_zero("stay_idle_after_reset");
        run_check(4'b1000, 0, 0, 1'b0, "after_reset_run");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_restart_abort();
        test_start_abort_idle();
        test_hold1();
        test_random();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
